qbus_master: RTL and testbench

- Parametrised QBUS bus-cycle master, the successor to the hand-timed cycles the QBUS bench drives by hand.
- Executes DATI (read), DATO (write) and DATIO (read-modify-write) cycles on the FPGA side of qdrv, with a configurable transfer length.
- All protocol timing is counted in qclk cycles, with a real no-existent-memory (NXM) timeout on RRPLY.
- Sits between the DMA/transfer logic and qdrv; multiple masters share T lines through wor nets.

---
 rtl/qbus_master.sv | 239 +++++++++++++++++++++++
 tb/tb_qbus_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbus_master.sv
// QBUS bus-cycle master: DATI/DATO/DATIO bursts with all protocol timing counted in qclk cycles.
// Bus drives decode combinationally from registered state; RRPLY is double-synchronised with an NXM timeout.
module qbus_master #(
  parameter int CLK_NS     = 50,
  parameter int ADDR_SETUP = 3,
  parameter int ADDR_HOLD  = 2,
  parameter int DATA_SETUP = 2,
  parameter int DATA_DLY   = 3,
  parameter int NXM_CYCLES = 200,
  parameter int LEN_W      = 8
) (
  input  logic              qclk,
  input  logic              reset_n,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [21:0]       addr,
  input  logic              bs7,
  input  logic [LEN_W-1:0]  len,
  input  logic [15:0]       wdata,
  output logic              wdata_req,
  output logic [15:0]       rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              nxm,
  input  logic [21:0]       DAL_in,
  output logic [21:0]       DAL_out,
  output logic              DALtx,
  output logic              TBS7,
  output logic              TWTBT,
  output logic              TSYNC,
  output logic              TDIN,
  output logic              TDOUT,
  input  logic              RRPLY
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_ADDR   = 4'd1;
  localparam logic [3:0] S_SYNC   = 4'd2;
  localparam logic [3:0] S_RD     = 4'd3;
  localparam logic [3:0] S_RD_END = 4'd4;
  localparam logic [3:0] S_WR     = 4'd5;
  localparam logic [3:0] S_WR_END = 4'd6;
  localparam logic [3:0] S_NEXT   = 4'd7;
  localparam logic [3:0] S_END    = 4'd8;

  localparam int TMR_W = $clog2(NXM_CYCLES + 1);

  localparam logic [7:0]       C_ADDR_SETUP = 8'(ADDR_SETUP - 1);
  localparam logic [7:0]       C_ADDR_HOLD  = 8'(ADDR_HOLD - 1);
  localparam logic [7:0]       C_DATA_SETUP = 8'(DATA_SETUP);
  localparam logic [7:0]       C_DATA_DLY   = 8'(DATA_DLY - 1);
  localparam logic [TMR_W-1:0] C_NXM_LAST   = TMR_W'(NXM_CYCLES - 1);

  // Reject parameter sets whose cycle counts fall short of the QBUS nanosecond minima.
  if (CLK_NS < 1 || CLK_NS * ADDR_SETUP < 150 || CLK_NS * ADDR_HOLD < 100 ||
      CLK_NS * DATA_SETUP < 100 || CLK_NS * DATA_DLY < 150 || NXM_CYCLES < 1) begin : g_timing_check
    $error("qbus_master: timing parameters below QBUS minima for this CLK_NS");
  end

  logic [3:0]       r_state;
  logic [1:0]       r_op;
  logic [21:0]      r_addr;
  logic             r_bs7;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word;
  logic [7:0]       r_cnt;
  logic [TMR_W-1:0] r_tmr;
  logic             r_got;
  logic [15:0]      r_wdat;
  logic [15:0]      r_rdata;
  logic             r_rdata_vld;
  logic             r_nxm;
  logic             r_rply_meta;
  logic             r_rply_s;

  logic w_is_dato;
  logic w_is_datio;
  logic w_addr_ph;
  logic w_data_ph;
  logic w_tdout;
  logic w_wdata_req;
  logic w_unused;

  assign w_unused = ^{addr[0], DAL_in[21:16]};

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      r_rply_meta <= 1'b0;
      r_rply_s    <= 1'b0;
    end else begin
      r_rply_meta <= RRPLY;
      r_rply_s    <= r_rply_meta;
    end
  end

  assign w_is_dato  = (r_op == 2'b01);
  assign w_is_datio = (r_op == 2'b10);
  assign w_addr_ph  = (r_state == S_ADDR) || (r_state == S_SYNC);
  assign w_data_ph  = (r_state == S_WR) || (r_state == S_WR_END);
  assign w_tdout    = (r_state == S_WR) && (r_cnt == C_DATA_SETUP);

  // The write word is captured on the edge that ends its request cycle and driven from the next cycle.
  assign w_wdata_req = ((r_state == S_SYNC) && (r_cnt == C_ADDR_HOLD) && w_is_dato) ||
                       ((r_state == S_RD_END) && !r_rply_s && w_is_datio);

  always_ff @(posedge qclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= 2'b00;
      r_addr      <= 22'd0;
      r_bs7       <= 1'b0;
      r_len       <= '0;
      r_word      <= '0;
      r_cnt       <= 8'd0;
      r_tmr       <= '0;
      r_got       <= 1'b0;
      r_wdat      <= 16'd0;
      r_rdata     <= 16'd0;
      r_rdata_vld <= 1'b0;
      r_nxm       <= 1'b0;
    end else begin
      r_rdata_vld <= 1'b0;
      if (w_wdata_req) r_wdat <= wdata;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_op    <= op;
            r_addr  <= {addr[21:1], 1'b0};
            r_bs7   <= bs7;
            r_len   <= len;
            r_word  <= '0;
            r_nxm   <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (r_cnt == C_ADDR_SETUP) begin
            r_cnt   <= 8'd0;
            r_state <= S_SYNC;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_SYNC: begin
          if (r_cnt == C_ADDR_HOLD) begin
            r_cnt   <= 8'd0;
            r_tmr   <= '0;
            r_got   <= 1'b0;
            r_state <= w_is_dato ? S_WR : S_RD;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RD: begin
          // Timeout only runs until the first reply; after that TDIN stays up for the data delay.
          if (!r_got) begin
            if (r_rply_s) begin
              r_got <= 1'b1;
              r_cnt <= 8'd0;
            end else if (r_tmr == C_NXM_LAST) begin
              r_nxm   <= 1'b1;
              r_state <= S_END;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end else if (r_cnt == C_DATA_DLY) begin
            r_rdata     <= DAL_in[15:0];
            r_rdata_vld <= 1'b1;
            r_state     <= S_RD_END;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RD_END: begin
          if (!r_rply_s) begin
            r_cnt   <= 8'd0;
            r_tmr   <= '0;
            r_state <= w_is_datio ? S_WR : S_NEXT;
          end
        end
        S_WR: begin
          if (!w_tdout) begin
            r_cnt <= r_cnt + 8'd1;
          end else if (r_rply_s) begin
            r_cnt   <= 8'd0;
            r_state <= S_WR_END;
          end else if (r_tmr == C_NXM_LAST) begin
            r_nxm   <= 1'b1;
            r_state <= S_END;
          end else begin
            r_tmr <= r_tmr + TMR_W'(1);
          end
        end
        S_WR_END: begin
          if (r_cnt != 8'd0) begin
            r_state <= S_NEXT;
          end else if (!r_rply_s) begin
            r_cnt <= 8'd1;
          end
        end
        S_NEXT: begin
          r_cnt <= 8'd0;
          if (r_word == r_len) begin
            r_state <= S_END;
          end else begin
            r_word  <= r_word + LEN_W'(1);
            r_addr  <= r_addr + 22'd2;
            r_state <= S_ADDR;
          end
        end
        S_END: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DALtx       = w_addr_ph || w_data_ph;
  assign DAL_out     = w_addr_ph ? r_addr : (w_data_ph ? {6'b0, r_wdat} : 22'd0);
  assign TBS7        = w_addr_ph && r_bs7;
  assign TWTBT       = w_addr_ph && w_is_dato;
  assign TSYNC       = (r_state == S_SYNC) || (r_state == S_RD) || (r_state == S_RD_END) || w_data_ph;
  assign TDIN        = (r_state == S_RD);
  assign TDOUT       = w_tdout;
  assign wdata_req   = w_wdata_req;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_vld;
  assign busy        = (r_state != S_IDLE) && (r_state != S_END);
  assign done        = (r_state == S_END);
  assign nxm         = r_nxm;

  a_no_din_dout: assert property (@(posedge qclk) disable iff (!reset_n) !(TDIN && TDOUT));

endmodule

// File: tb/tb_qbus_master.sv
// Directed bench for qbus_master with a reactive QBUS slave memory (no reply at 'o17400).
`timescale 1ns/1ps
module tb_qbus_master;

  logic        qclk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [21:0] addr = 22'd0;
  logic        bs7 = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] wdata = 16'd0;
  logic        wdata_req;
  logic [15:0] rdata;
  logic        rdata_valid;
  logic        busy;
  logic        done;
  logic        nxm;
  logic [21:0] DAL_in = 22'd0;
  logic [21:0] DAL_out;
  logic        DALtx;
  logic        TBS7, TWTBT, TSYNC, TDIN, TDOUT;
  logic        RRPLY = 1'b0;

  qbus_master dut (
    .qclk(qclk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .bs7(bs7),
    .len(len), .wdata(wdata), .wdata_req(wdata_req), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .nxm(nxm),
    .DAL_in(DAL_in), .DAL_out(DAL_out), .DALtx(DALtx), .TBS7(TBS7), .TWTBT(TWTBT),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .RRPLY(RRPLY)
  );

  always #5 qclk = ~qclk;

  int n_cmp = 0;
  int n_fail = 0;

  // Slave memory: latches the address when TSYNC rises, replies one half-cycle after TDIN/TDOUT.
  localparam logic [21:0] UNMAPPED = 22'o17400;
  logic [15:0] mem [logic [21:0]];
  logic [21:0] s_addr = 22'd0;
  logic        s_sync_d = 1'b0;

  always @(negedge qclk) begin
    if (TSYNC && !s_sync_d) s_addr = DAL_out;
    s_sync_d = TSYNC;
    if (TDIN && s_addr != UNMAPPED) begin
      DAL_in = {6'b0, mem.exists(s_addr) ? mem[s_addr] : 16'd0};
      RRPLY  = 1'b1;
    end else if (TDOUT && s_addr != UNMAPPED) begin
      if (!RRPLY) mem[s_addr] = DAL_out[15:0];
      RRPLY = 1'b1;
    end else begin
      RRPLY = 1'b0;
    end
  end

  // Bus monitor sampled on the falling edge.
  int mcyc = 0, dal_rise_cyc = 0, tbs_rise_cyc = 0, sync_rise_cyc = 0;
  int sync_rises = 0, tdin_rises = 0, tdout_rises = 0, tdin_run = 0, tdin_last_run = 0;
  int twtbt_hi = 0, twtbt_bad = 0, both_bad = 0, dal_stable = 0, setup_at_tdout = 0;
  logic [21:0] sync_addr [0:7];
  logic p_dal = 1'b0, p_tbs = 1'b0, p_sync = 1'b0, p_tdin = 1'b0, p_tdout = 1'b0;
  logic [21:0] p_dalv = 22'd0;

  always @(negedge qclk) begin
    mcyc++;
    if (DALtx && !p_dal) dal_rise_cyc = mcyc;
    if (TBS7 && !p_tbs) tbs_rise_cyc = mcyc;
    if (TSYNC && !p_sync) begin
      sync_rise_cyc = mcyc;
      if (sync_rises < 8) sync_addr[sync_rises] = DAL_out;
      sync_rises++;
    end
    if (TDIN && !p_tdin) tdin_rises++;
    if (TDIN) tdin_run++;
    else if (p_tdin) begin tdin_last_run = tdin_run; tdin_run = 0; end
    if (DALtx && p_dal && DAL_out == p_dalv) dal_stable++;
    else dal_stable = 0;
    if (TDOUT && !p_tdout) begin tdout_rises++; setup_at_tdout = dal_stable; end
    if (TWTBT) twtbt_hi++;
    if (TWTBT && (TDIN || TDOUT || !DALtx)) twtbt_bad++;
    if (TDIN && TDOUT) both_bad++;
    p_dal = DALtx; p_tbs = TBS7; p_sync = TSYNC; p_tdin = TDIN; p_tdout = TDOUT; p_dalv = DAL_out;
  end

  function automatic void mon_clear();
    dal_rise_cyc = 0; tbs_rise_cyc = 0; sync_rise_cyc = 0; sync_rises = 0;
    tdin_rises = 0; tdout_rises = 0; tdin_run = 0; tdin_last_run = 0;
    twtbt_hi = 0; twtbt_bad = 0; both_bad = 0; setup_at_tdout = 0;
  endfunction

  logic [15:0] wq [0:7];
  logic [15:0] rq [0:7];
  int          nrv, nwreq;
  logic        x_nxm;
  logic [6:0]  x_lines;

  task automatic xfer(input logic [1:0] t_op, input logic [21:0] t_addr,
                      input logic t_bs7, input logic [7:0] t_len);
    int  wi, cyc;
    logic adv, x_to;
    @(posedge qclk); #1;
    mon_clear();
    nrv = 0; nwreq = 0; wi = 0; adv = 1'b0; x_to = 1'b0; cyc = 0;
    x_nxm = 1'bx; x_lines = 7'h7f;
    wdata = wq[0];
    @(negedge qclk);
    op = t_op; addr = t_addr; bs7 = t_bs7; len = t_len; req = 1'b1;
    @(negedge qclk);
    req = 1'b0;
    while (1) begin
      if (adv) begin
        wi++;
        if (wi < 8) wdata = wq[wi];
        adv = 1'b0;
      end
      if (wdata_req) begin nwreq++; adv = 1'b1; end
      if (rdata_valid) begin
        if (nrv < 8) rq[nrv] = rdata;
        nrv++;
      end
      if (done) begin
        x_nxm = nxm;
        x_lines = {TSYNC, TDIN, TDOUT, DALtx, TBS7, TWTBT, busy};
        break;
      end
      if (cyc >= 3000) begin x_to = 1'b1; break; end
      @(negedge qclk);
      cyc++;
    end
    #1;
    n_cmp++;
    if (x_to) begin n_fail++; $display("FAIL xfer_done_timeout: done=%b after %0d cycles, required done=1", done, cyc); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge qclk);
    n_cmp++;
    if ({busy, done, nxm, DALtx, TBS7, TWTBT, TSYNC, TDIN, TDOUT, wdata_req, rdata_valid} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 0", {busy, done, nxm, DALtx, TBS7, TWTBT, TSYNC, TDIN, TDOUT, wdata_req, rdata_valid});
    end
    n_cmp++;
    if ({DAL_out, rdata} !== 38'd0) begin n_fail++; $display("FAIL reset_data: DAL_out=%o rdata=%o required 0", DAL_out, rdata); end
    reset_n = 1'b1;
  endtask

  task automatic test_dati();
    xfer(2'b00, 22'o17774, 1'b1, 8'd0);
    n_cmp++;
    if (sync_rise_cyc - dal_rise_cyc !== 3) begin n_fail++; $display("FAIL dati_addr_setup: got %0d cycles required 3", sync_rise_cyc - dal_rise_cyc); end
    n_cmp++;
    if (tbs_rise_cyc !== dal_rise_cyc) begin n_fail++; $display("FAIL dati_tbs7_rise: got cycle %0d required %0d", tbs_rise_cyc, dal_rise_cyc); end
    n_cmp++;
    if (nrv !== 1 || rq[0] !== 16'o123456) begin n_fail++; $display("FAIL dati_rdata: got %0d words first %o required 1 word 123456", nrv, rq[0]); end
    n_cmp++;
    if (x_nxm !== 1'b0 || x_lines !== 7'b0) begin n_fail++; $display("FAIL dati_done: nxm=%b lines=%b required nxm=0 lines=0", x_nxm, x_lines); end
    n_cmp++;
    if (twtbt_hi !== 0) begin n_fail++; $display("FAIL dati_twtbt: got %0d high cycles required 0", twtbt_hi); end
    // Reserved op reads, and address bit 0 is dropped.
    xfer(2'b11, 22'o17775, 1'b1, 8'd0);
    n_cmp++;
    if (sync_addr[0] !== 22'o17774) begin n_fail++; $display("FAIL rsvd_addr: got %o required 17774", sync_addr[0]); end
    n_cmp++;
    if (nrv !== 1 || rq[0] !== 16'o123456 || twtbt_hi !== 0) begin n_fail++; $display("FAIL rsvd_read: nrv=%0d data=%o twtbt=%0d required 1/123456/0", nrv, rq[0], twtbt_hi); end
  endtask

  task automatic test_dato_dati();
    wq[0] = 16'o054321;
    xfer(2'b01, 22'o17774, 1'b1, 8'd0);
    n_cmp++;
    if (nwreq !== 1) begin n_fail++; $display("FAIL dato_wreq: got %0d required 1", nwreq); end
    n_cmp++;
    if (twtbt_hi !== 5 || twtbt_bad !== 0) begin n_fail++; $display("FAIL dato_twtbt: high=%0d bad=%0d required 5/0", twtbt_hi, twtbt_bad); end
    n_cmp++;
    if (setup_at_tdout < 2) begin n_fail++; $display("FAIL dato_data_setup: got %0d required >=2", setup_at_tdout); end
    n_cmp++;
    if (x_nxm !== 1'b0 || x_lines !== 7'b0) begin n_fail++; $display("FAIL dato_done: nxm=%b lines=%b required 0/0", x_nxm, x_lines); end
    xfer(2'b00, 22'o17774, 1'b1, 8'd0);
    n_cmp++;
    if (nrv !== 1 || rq[0] !== 16'o054321) begin n_fail++; $display("FAIL dato_readback: got %o required 054321", rq[0]); end
  endtask

  task automatic test_datio();
    wq[0] = 16'o054545;
    xfer(2'b10, 22'o17760, 1'b1, 8'd0);
    n_cmp++;
    if (sync_rises !== 1 || tdin_rises !== 1 || tdout_rises !== 1) begin
      n_fail++; $display("FAIL datio_single_sync: sync=%0d tdin=%0d tdout=%0d required 1/1/1", sync_rises, tdin_rises, tdout_rises);
    end
    n_cmp++;
    if (nrv !== 1 || rq[0] !== 16'o123456 || nwreq !== 1) begin n_fail++; $display("FAIL datio_read: nrv=%0d data=%o wreq=%0d required 1/123456/1", nrv, rq[0], nwreq); end
    n_cmp++;
    if (setup_at_tdout < 2 || both_bad !== 0) begin n_fail++; $display("FAIL datio_setup: setup=%0d overlap=%0d required >=2/0", setup_at_tdout, both_bad); end
    xfer(2'b00, 22'o17760, 1'b1, 8'd0);
    n_cmp++;
    if (rq[0] !== 16'o054545) begin n_fail++; $display("FAIL datio_readback: got %o required 054545", rq[0]); end
  endtask

  task automatic test_nxm();
    xfer(2'b00, 22'o17400, 1'b1, 8'd0);
    n_cmp++;
    if (tdin_last_run !== 200) begin n_fail++; $display("FAIL nxm_tdin_len: got %0d cycles required 200", tdin_last_run); end
    n_cmp++;
    if (x_nxm !== 1'b1 || x_lines !== 7'b0 || nrv !== 0) begin n_fail++; $display("FAIL nxm_done: nxm=%b lines=%b nrv=%0d required 1/0/0", x_nxm, x_lines, nrv); end
    repeat (3) @(negedge qclk);
    n_cmp++;
    if (nxm !== 1'b1) begin n_fail++; $display("FAIL nxm_hold: got %b required 1", nxm); end
    xfer(2'b00, 22'o17774, 1'b1, 8'd0);
    n_cmp++;
    if (x_nxm !== 1'b0 || rq[0] !== 16'o054321) begin n_fail++; $display("FAIL nxm_clear: nxm=%b data=%o required 0/054321", x_nxm, rq[0]); end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp_a;
    wq[0] = 16'o000111; wq[1] = 16'o000222; wq[2] = 16'o000333; wq[3] = 16'o000444;
    xfer(2'b01, 22'o1000, 1'b0, 8'd3);
    n_cmp++;
    if (nwreq !== 4 || sync_rises !== 4) begin n_fail++; $display("FAIL burst_counts: wreq=%0d sync=%0d required 4/4", nwreq, sync_rises); end
    for (int i = 0; i < 4; i++) begin
      exp_a = 22'o1000 + 22'(2 * i);
      n_cmp++;
      if (sync_addr[i] !== exp_a) begin n_fail++; $display("FAIL burst_addr%0d: got %o required %o", i, sync_addr[i], exp_a); end
    end
    xfer(2'b00, 22'o1000, 1'b0, 8'd3);
    n_cmp++;
    if (nrv !== 4) begin n_fail++; $display("FAIL burst_read_count: got %0d required 4", nrv); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rq[i] !== wq[i]) begin n_fail++; $display("FAIL burst_readback%0d: got %o required %o", i, rq[i], wq[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    @(negedge qclk);
    op = 2'b00; addr = 22'o17400; bs7 = 1'b1; len = 8'd0; req = 1'b1;
    @(negedge qclk);
    req = 1'b0;
    k = 0;
    while (!TDIN && k < 50) begin @(negedge qclk); k++; end
    n_cmp++;
    if (TDIN !== 1'b1) begin n_fail++; $display("FAIL rstmid_tdin: got %b required 1", TDIN); end
    repeat (10) @(negedge qclk);
    #3 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({TSYNC, TDIN, TDOUT, DALtx, TBS7, TWTBT, busy} !== 7'b0) begin
      n_fail++; $display("FAIL rstmid_release: got %b required 0", {TSYNC, TDIN, TDOUT, DALtx, TBS7, TWTBT, busy});
    end
    @(negedge qclk);
    reset_n = 1'b1;
    xfer(2'b00, 22'o17774, 1'b1, 8'd0);
    n_cmp++;
    if (nrv !== 1 || rq[0] !== 16'o054321 || x_nxm !== 1'b0) begin n_fail++; $display("FAIL rstmid_after: nrv=%0d data=%o nxm=%b required 1/054321/0", nrv, rq[0], x_nxm); end
  endtask

  initial begin
    mem[22'o17774] = 16'o123456;
    mem[22'o17760] = 16'o123456;
    for (int i = 0; i < 8; i++) begin wq[i] = 16'd0; rq[i] = 16'd0; sync_addr[i] = 22'd0; end
    test_reset();
    test_dati();
    test_dato_dati();
    test_datio();
    test_nxm();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
